// File: rtl/jtdd_scan2x_pkg.sv
// Shared definitions for the line-doubling scan converter: buffer word layout,
// default geometry and the read-side state encoding.
package jtdd_scan2x_pkg;

    localparam int BW       = 14;
    localparam int RGB_LSB  = 0;
    localparam int LHBL_BIT = 12;
    localparam int LVBL_BIT = 13;

    localparam int DEF_AW  = 9;
    localparam int DEF_HSW = 32;

    // Read side: idle, first replay of the stored line, second replay.
    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_PASS0 = 2'd1,
        RD_PASS1 = 2'd2
    } rd_state_e;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       lhbl;
        logic       lvbl;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } vout_t;

    function automatic logic [BW-1:0] pack_word(input logic lvbl, input logic lhbl,
                                                input logic [3:0] r, input logic [3:0] g,
                                                input logic [3:0] b);
        return {lvbl, lhbl, r, g, b};
    endfunction

endpackage

// File: rtl/jtdd_scan2x_linebuf.sv
// Two-bank line store: one write port and one registered read port, both
// addressed as {bank, pixel}.
module jtdd_scan2x_linebuf
    import jtdd_scan2x_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW:0]   waddr_i,
    input  logic [BW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW:0]   raddr_i,
    output logic [BW-1:0] rdata_o
);

    localparam int DEPTH = 2 ** (AW + 1);

    logic [BW-1:0] mem_q [0:DEPTH-1];
    logic [BW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/jtdd_scan2x.sv
// 15 kHz to 31 kHz line doubler: each input line is written to one bank while
// the previous line is replayed twice from the other bank at pxl2_cen rate.
module jtdd_scan2x
    import jtdd_scan2x_pkg::*;
#(
    parameter int AW  = DEF_AW,
    parameter int HSW = DEF_HSW
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pxl_cen,
    input  logic       pxl2_cen,
    input  logic       en,
    input  logic       HS,
    input  logic       VS,
    input  logic       LHBL_dly,
    input  logic       LVBL_dly,
    input  logic [3:0] red,
    input  logic [3:0] green,
    input  logic [3:0] blue,
    output logic       hs2,
    output logic       vs2,
    output logic       lhbl2,
    output logic       lvbl2,
    output logic [3:0] red2,
    output logic [3:0] green2,
    output logic [3:0] blue2
);

    localparam logic [AW-1:0] CNT_MAX = '1;
    localparam logic [AW-1:0] CNT_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [AW-1:0] line_len_q, line_len_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;
    logic          wr_bank_q, wr_bank_d;
    logic          hs_last_q, hs_last_d;
    logic          vs_line_q, vs_line_d;
    rd_state_e     rd_state_q, rd_state_d;
    logic          s1_hs_q, s1_hs_d;
    logic          s1_vs_q, s1_vs_d;
    logic          s1_idle_q, s1_idle_d;
    vout_t         out_q, out_d;

    logic          hs_edge;
    logic [AW:0]   waddr;
    logic [AW:0]   raddr;
    logic [BW-1:0] rd_word;

    assign hs_edge = pxl_cen && HS && !hs_last_q;

    // On an HS edge the current pixel opens the new line in the other bank.
    assign waddr = hs_edge ? {~wr_bank_q, {AW{1'b0}}} : {wr_bank_q, wr_cnt_q};
    assign raddr = {~wr_bank_q, rd_cnt_q};

    jtdd_scan2x_linebuf #(.AW(AW)) u_linebuf (
        .clk_i   (clk),
        .we_i    (pxl_cen),
        .waddr_i (waddr),
        .wdata_i (pack_word(LVBL_dly, LHBL_dly, red, green, blue)),
        .re_i    (pxl2_cen),
        .raddr_i (raddr),
        .rdata_o (rd_word)
    );

    always_comb begin
        wr_cnt_d   = wr_cnt_q;
        line_len_d = line_len_q;
        wr_bank_d  = wr_bank_q;
        hs_last_d  = hs_last_q;
        rd_cnt_d   = rd_cnt_q;
        vs_line_d  = vs_line_q;
        rd_state_d = rd_state_q;

        if (pxl_cen) begin
            hs_last_d = HS;
            if (hs_edge) begin
                line_len_d = wr_cnt_q;
                wr_cnt_d   = CNT_ONE;
                wr_bank_d  = ~wr_bank_q;
            end else if (wr_cnt_q != CNT_MAX) begin
                wr_cnt_d = wr_cnt_q + CNT_ONE;
            end
        end

        // A new line always wins over an unfinished replay.
        if (hs_edge) begin
            rd_cnt_d   = '0;
            vs_line_d  = VS;
            rd_state_d = (wr_cnt_q == '0) ? RD_IDLE : RD_PASS0;
        end else if (pxl2_cen && rd_state_q != RD_IDLE) begin
            if (rd_cnt_q == line_len_q - CNT_ONE) begin
                rd_cnt_d   = '0;
                rd_state_d = (rd_state_q == RD_PASS0) ? RD_PASS1 : RD_IDLE;
            end else begin
                rd_cnt_d = rd_cnt_q + CNT_ONE;
            end
        end
    end

    always_comb begin
        s1_hs_d   = s1_hs_q;
        s1_vs_d   = s1_vs_q;
        s1_idle_d = s1_idle_q;
        out_d     = out_q;

        // Sideband follows the RAM read so syncs stay aligned with pixel data.
        if (pxl2_cen) begin
            s1_hs_d   = (32'(rd_cnt_q) < HSW) && (rd_state_q != RD_IDLE);
            s1_vs_d   = vs_line_q;
            s1_idle_d = (rd_state_q == RD_IDLE);
        end

        if (!en) begin
            if (pxl_cen) begin
                out_d.hs   = HS;
                out_d.vs   = VS;
                out_d.lhbl = LHBL_dly;
                out_d.lvbl = LVBL_dly;
                out_d.r    = red;
                out_d.g    = green;
                out_d.b    = blue;
            end
        end else if (pxl2_cen) begin
            out_d.hs = s1_hs_q;
            out_d.vs = s1_vs_q;
            if (s1_idle_q) begin
                out_d.lhbl = 1'b0;
                out_d.lvbl = 1'b0;
                out_d.r    = '0;
                out_d.g    = '0;
                out_d.b    = '0;
            end else begin
                out_d.lhbl = rd_word[LHBL_BIT];
                out_d.lvbl = rd_word[LVBL_BIT];
                out_d.r    = rd_word[RGB_LSB+8 +: 4];
                out_d.g    = rd_word[RGB_LSB+4 +: 4];
                out_d.b    = rd_word[RGB_LSB +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q   <= '0;
            line_len_q <= '0;
            wr_bank_q  <= 1'b0;
            hs_last_q  <= 1'b0;
            rd_cnt_q   <= '0;
            vs_line_q  <= 1'b0;
            rd_state_q <= RD_IDLE;
            s1_hs_q    <= 1'b0;
            s1_vs_q    <= 1'b0;
            s1_idle_q  <= 1'b1;
            out_q      <= '0;
        end else begin
            wr_cnt_q   <= wr_cnt_d;
            line_len_q <= line_len_d;
            wr_bank_q  <= wr_bank_d;
            hs_last_q  <= hs_last_d;
            rd_cnt_q   <= rd_cnt_d;
            vs_line_q  <= vs_line_d;
            rd_state_q <= rd_state_d;
            s1_hs_q    <= s1_hs_d;
            s1_vs_q    <= s1_vs_d;
            s1_idle_q  <= s1_idle_d;
            out_q      <= out_d;
        end
    end

    assign hs2    = out_q.hs;
    assign vs2    = out_q.vs;
    assign lhbl2  = out_q.lhbl;
    assign lvbl2  = out_q.lvbl;
    assign red2   = out_q.r;
    assign green2 = out_q.g;
    assign blue2  = out_q.b;

endmodule
